// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied in a single FIX cycle before the result lands.
module mips_muldiv_unit #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [NBits-1:0] OperandA,
  input  logic [NBits-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [NBits-1:0] HI,
  output logic [NBits-1:0] LO
);

  localparam int CntW = $clog2(NBits);
  localparam logic [2:0] OpMthi = 3'b100;
  localparam logic [2:0] OpMtlo = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic [2*NBits-1:0] acc_q;
  logic [NBits-1:0]   opnd_q;
  logic [NBits-1:0]   hi_q, lo_q;
  logic               isDiv_q, negRes_q, negRem_q, dbz_q;

  logic               accept, isArith, isSigned, divZero, isMt;
  logic [NBits-1:0]   magA, magB;
  logic [NBits:0]     mulSum, divShift, divDiff;
  logic [2*NBits-1:0] mulNext, divNext, prodFixed;
  logic [NBits-1:0]   quotFixed, remFixed;

  // Decode the launch request; a new op is taken in IDLE or in the DONE cycle.
  always_comb begin
    accept   = ((state_q == IDLE) || (state_q == DONE)) && Start && !Flush;
    isArith  = (Op[2] == 1'b0);
    isSigned = isArith && !Op[0];
    divZero  = isArith && Op[1] && (OperandB == '0);
    isMt     = (Op == OpMthi) || (Op == OpMtlo);
    magA     = (isSigned && OperandA[NBits-1]) ? -OperandA : OperandA;
    magB     = (isSigned && OperandB[NBits-1]) ? -OperandB : OperandB;
  end

  // One radix-2 step: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*NBits-1:NBits]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mulNext  = {mulSum, acc_q[NBits-1:1]};
    divShift = acc_q[2*NBits-1:NBits-1];
    divDiff  = divShift - {1'b0, opnd_q};
    if (!divDiff[NBits])
      divNext = {divDiff[NBits-1:0], acc_q[NBits-2:0], 1'b1};
    else
      divNext = {divShift[NBits-1:0], acc_q[NBits-2:0], 1'b0};
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    prodFixed = negRes_q ? -acc_q : acc_q;
    quotFixed = negRes_q ? -acc_q[NBits-1:0] : acc_q[NBits-1:0];
    remFixed  = negRem_q ? -acc_q[2*NBits-1:NBits] : acc_q[2*NBits-1:NBits];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; Flush abandons any in-flight or completing operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (divZero || isMt) state_d = DONE;
          else if (isArith)    state_d = RUN;
        end
      end
      RUN: begin
        if (Flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = FIX;
      end
      FIX:     state_d = Flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registered state, never from the inputs.
  always_comb begin
    Busy      = (state_q == RUN) || (state_q == FIX);
    Done      = (state_q == DONE);
    DivByZero = dbz_q;
    HI        = hi_q;
    LO        = lo_q;
  end

  // Datapath: operand capture, iteration, and HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      dbz_q <= accept && divZero;
      if (accept && isArith && !divZero) begin
        acc_q    <= {{NBits{1'b0}}, (Op[1] ? magA : magB)};
        opnd_q   <= Op[1] ? magB : magA;
        cnt_q    <= CntW'(NBits - 1);
        isDiv_q  <= Op[1];
        negRes_q <= isSigned && (OperandA[NBits-1] ^ OperandB[NBits-1]);
        negRem_q <= isSigned && OperandA[NBits-1];
      end else if (accept && divZero) begin
        lo_q <= '1;
        hi_q <= OperandA;
      end else if (accept && (Op == OpMthi)) begin
        hi_q <= OperandA;
      end else if (accept && (Op == OpMtlo)) begin
        lo_q <= OperandA;
      end else if ((state_q == RUN) && !Flush) begin
        acc_q <= isDiv_q ? divNext : mulNext;
        cnt_q <= cnt_q - 1'b1;
      end else if ((state_q == FIX) && !Flush) begin
        hi_q <= isDiv_q ? remFixed  : prodFixed[2*NBits-1:NBits];
        lo_q <= isDiv_q ? quotFixed : prodFixed[NBits-1:0];
      end
    end
  end

endmodule
